mdu_issue_ctrl: RTL
===================

Name: mdu_issue_ctrl

Overview:
Sequencing controller for the pipeline's multiply/divide unit (HI/LO datapath).
- Takes the MD-class op held in the E stage and issues a one-cycle start with the decoded op to the MDU.
- Times the multi-cycle operation and pulses the HI/LO commit.
- Drives the D-stage stall for MD-class instructions while the unit is occupied.
- Sits between the E-stage pipeline register and the MDU datapath; the hazard unit consumes it.

Parameters:
MUL_CYCLES  5   busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES  10  busy cycles for div/divu (legal range 1..15)

Ports:
clk          in   1   clock
reset        in   1   synchronous, active-high reset
e_op_valid   in   1   E stage holds a valid MD-class instruction
e_op         in   4   op code: 0000 mult, 0001 multu, 0010 div, 0011 divu, 0100 mfhi, 0101 mflo, 0110 mthi, 0111 mtlo; any other value = no op
e_flush      in   1   E-stage instruction is being flushed (exception/interrupt)
d_md_valid   in   1   D stage holds an MD-class instruction
mdu_start    out  1   one-cycle start pulse to the MDU (combinational)
mdu_op       out  4   op presented to the MDU; 4'b1111 = none (combinational)
mdu_commit   out  1   one-cycle pulse: MDU latches its result into HI/LO
busy         out  1   operation in flight (registered)
stall_d      out  1   stall the D stage (combinational)
stall_cnt    out  32  count of stall_d cycles, saturating

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: state = IDLE, cnt = 0, busy = 0, stall_cnt = 0. With e_op_valid = 0 and d_md_valid = 0, every combinational output is 0 and mdu_op = 4'b1111.
- State is IDLE or RUN; cnt is a 4-bit down-counter.
- Let issue = e_op_valid & ~e_flush & ~busy.
- IDLE, issue, e_op in {mult, multu}:
  - mdu_start = 1 and mdu_op = e_op in the same cycle.
  - Next state RUN, cnt <= MUL_CYCLES.
- IDLE, issue, e_op in {div, divu}: same as above, with cnt <= DIV_CYCLES.
- IDLE, issue, e_op in {mfhi, mflo, mthi, mtlo}:
  - mdu_op = e_op, mdu_start = 0; state stays IDLE.
- IDLE, e_op any other code: treated as no op; mdu_op = 4'b1111, no start.
- e_flush = 1 in IDLE: the E-stage op is suppressed; no start, mdu_op = 4'b1111.
- RUN:
  - busy = 1; mdu_op = 4'b1111; any e_op is ignored (protocol violation, since stall_d prevents it).
  - cnt decrements each cycle.
  - When cnt == 1: mdu_commit = 1, and at the clock edge state goes to IDLE with cnt = 0.
- Latency for an op issued in cycle T with N busy cycles:
  - busy is high in cycles T+1 .. T+N.
  - mdu_commit fires in cycle T+N.
  - A new start is accepted in cycle T+N+1 at the earliest.
  - Back-to-back MD ops therefore see exactly N+1 stall cycles.
- stall_d = d_md_valid & (busy | mdu_start).
  - The stall covers cycles T .. T+N.
  - An mfhi/mflo in D therefore never reads stale HI/LO.
- stall_cnt increments on every cycle stall_d = 1 and holds at 32'hFFFF_FFFF. It is cleared only by reset.
- Reset mid-operation: an immediate return to IDLE; no commit is issued and the in-flight result is dropped.
- e_flush while in RUN: ignored by default; the operation completes and commits (see Optional Feature).
- Parameter value 1: RUN lasts one cycle, and mdu_commit fires in the first RUN cycle.

Optional Feature:
- Macro: MDU_FLUSH_ABORT_EN.
- Defined: e_flush = 1 in RUN aborts the operation.
  - At the next edge: state goes to IDLE, cnt = 0, busy = 0.
  - mdu_commit is suppressed, including when cnt == 1 in that same cycle.
  - stall_d drops one cycle after the flush.
- Undefined: e_flush has no effect in RUN; the operation always commits.

Test Plan:
- Reset, then idle inputs -> busy = 0, mdu_start = 0, mdu_commit = 0, mdu_op = 4'b1111, stall_cnt = 0.
- mult in E at T with d_md_valid = 1 throughout -> mdu_start at T; busy in T+1..T+5; mdu_commit only at T+5; stall_d in T..T+5; stall_cnt = 6.
- div then mflo back-to-back -> commit at T+10; mflo in E at T+11 passes through with mdu_op = 0101 and no start; 11 stall cycles.
- mthi in E in IDLE -> mdu_op = 0110, mdu_start = 0, busy stays 0; e_flush with mult in E -> no start, state remains IDLE.
- Reset asserted at T+3 of a div -> busy = 0 next cycle, no mdu_commit ever issued; a mult at T+5 starts normally.
- Flush during RUN at T+4 of a div:
  - With MDU_FLUSH_ABORT_EN: busy = 0 at T+5, no commit.
  - Without the macro: commit at T+10.

Source files
------------

// File: rtl/mdu_issue_ctrl.sv
// Issue/sequencing control for the HI/LO multiply-divide unit: start pulse, busy timing, commit pulse, D-stage stall.
// Optional MDU_FLUSH_ABORT_EN: an E-stage flush while running aborts the operation and suppresses its commit.
module mdu_issue_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_op_valid,
  input  logic [3:0]  e_op,
  input  logic        e_flush,
  input  logic        d_md_valid,
  output logic        mdu_start,
  output logic [3:0]  mdu_op,
  output logic        mdu_commit,
  output logic        busy,
  output logic        stall_d,
  output logic [31:0] stall_cnt
);

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MFHI  = 4'b0100;
  localparam logic [3:0] OP_MFLO  = 4'b0101;
  localparam logic [3:0] OP_MTHI  = 4'b0110;
  localparam logic [3:0] OP_MTLO  = 4'b0111;
  localparam logic [3:0] OP_NONE  = 4'b1111;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        r_busy;
  logic [31:0] r_stall_cnt;
  logic        w_issue;
  logic        w_abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    mdu_start   = 1'b0;
    mdu_op      = OP_NONE;
    mdu_commit  = 1'b0;
    w_abort     = 1'b0;
    w_issue     = e_op_valid & ~e_flush & ~r_busy;

    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          case (e_op)
            OP_MULT, OP_MULTU: begin
              mdu_start   = 1'b1;
              mdu_op      = e_op;
              w_state_nxt = S_RUN;
              w_cnt_nxt   = MUL_LOAD;
            end
            OP_DIV, OP_DIVU: begin
              mdu_start   = 1'b1;
              mdu_op      = e_op;
              w_state_nxt = S_RUN;
              w_cnt_nxt   = DIV_LOAD;
            end
            // HI/LO moves complete in the datapath without occupying the unit
            OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: begin
              mdu_op = e_op;
            end
            default: begin
              mdu_op = OP_NONE;
            end
          endcase
        end
      end

      S_RUN: begin
`ifdef MDU_FLUSH_ABORT_EN
        w_abort = e_flush;
`endif
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == 4'd1) begin
          mdu_commit  = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Stall also covers the issue cycle so an mfhi/mflo in D cannot slip past a start
  assign stall_d = d_md_valid & (r_busy | mdu_start);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= 32'd0;
    end else if (stall_d && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign busy      = r_busy;
  assign stall_cnt = r_stall_cnt;

endmodule
